// File: rtl/cvex_mem_arbiter_if.sv
// Bus bundle between the cvex top level / CPU requesters / RAM macro and the
// memory arbiter. The slave modport is the arbiter's view; master is the
// view of everything around it (debug port, CPU buses and the RAM read data).
interface cvex_mem_arbiter_if #(
    parameter int ADDR_W = 14
);
    // debug loader port
    logic              dbg_mem_op;
    logic [3:0]        dbg_wren;
    logic [31:0]       dbg_adr;
    logic [31:0]       dbg_do;
    logic [31:0]       dbg_di;

    // CPU instruction bus
    logic              ibus_cmd_valid;
    logic              ibus_cmd_ready;
    logic [31:0]       ibus_adr;
    logic              ibus_rsp_valid;
    logic [31:0]       ibus_rsp_data;

    // CPU data bus
    logic              dbus_cmd_valid;
    logic              dbus_cmd_ready;
    logic              dbus_wr;
    logic [3:0]        dbus_mask;
    logic [31:0]       dbus_adr;
    logic [31:0]       dbus_wdata;
    logic              dbus_rsp_valid;
    logic [31:0]       dbus_rsp_data;

    // single-port RAM macro
    logic [ADDR_W-1:0] ram_adr;
    logic [3:0]        ram_wren;
    logic [31:0]       ram_di;
    logic [31:0]       ram_do;

    modport slave (
        input  dbg_mem_op, dbg_wren, dbg_adr, dbg_do,
        output dbg_di,
        input  ibus_cmd_valid, ibus_adr,
        output ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_data,
        input  dbus_cmd_valid, dbus_wr, dbus_mask, dbus_adr, dbus_wdata,
        output dbus_cmd_ready, dbus_rsp_valid, dbus_rsp_data,
        output ram_adr, ram_wren, ram_di,
        input  ram_do
    );

    modport master (
        output dbg_mem_op, dbg_wren, dbg_adr, dbg_do,
        input  dbg_di,
        output ibus_cmd_valid, ibus_adr,
        input  ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_data,
        output dbus_cmd_valid, dbus_wr, dbus_mask, dbus_adr, dbus_wdata,
        input  dbus_cmd_ready, dbus_rsp_valid, dbus_rsp_data,
        input  ram_adr, ram_wren, ram_di,
        output ram_do
    );
endinterface

// File: rtl/cvex_mem_arbiter.sv
// Shares the single-port word RAM between the debug loader, the CPU data bus
// and the CPU instruction bus, and sequences the CPU reset. Debug always wins
// and holds the CPU in reset; the CPU buses are round-robin arbitrated once
// the CPU has been released.
module cvex_mem_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int RST_HOLD = 4
) (
    input  logic                clk,
    input  logic                n_reset,
    cvex_mem_arbiter_if.slave   bus,
    output logic                cpu_n_reset
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DEBUG = 2'd3
    } state_e;

    localparam logic [7:0] HOLD_INIT = 8'(RST_HOLD);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rr_q, rr_d;                 // last granted CPU port: 1 = dbus, 0 = ibus
    logic        cpu_n_reset_q, cpu_n_reset_d;
    logic        ibus_rsp_valid_q, ibus_rsp_valid_d;
    logic        dbus_rsp_valid_q, dbus_rsp_valid_d;
    logic        dbg_rd_q, dbg_rd_d;         // a debug read was issued last cycle
    logic [31:0] dbg_di_q, dbg_di_d;         // last captured debug read data
    logic        ibus_gnt_s;
    logic        dbus_gnt_s;

    // Address bits above the RAM size and the byte offset are intentionally dropped.
    logic unused_adr_s;
    assign unused_adr_s = ^{bus.dbg_adr[31:ADDR_W+2], bus.dbg_adr[1:0],
                            bus.ibus_adr[31:ADDR_W+2], bus.ibus_adr[1:0],
                            bus.dbus_adr[31:ADDR_W+2], bus.dbus_adr[1:0]};

    // Reset sequencer next state: RST -> HOLD countdown -> RUN, debug parks in DEBUG.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RST: begin
                state_d = ST_HOLD;
                cnt_d   = HOLD_INIT;
            end
            ST_HOLD: begin
                cnt_d = cnt_q - 8'd1;
                if (bus.dbg_mem_op) begin
                    state_d = ST_DEBUG;
                end else if (cnt_q == 8'd1) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_RUN: begin
                if (bus.dbg_mem_op) begin
                    state_d = ST_DEBUG;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DEBUG: begin
                if (!bus.dbg_mem_op) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_INIT;
                end else begin
                    state_d = ST_DEBUG;
                end
            end
            default: begin
                state_d = ST_RST;
                cnt_d   = HOLD_INIT;
            end
        endcase
    end

    // Single-access-per-cycle RAM grant: debug first, then round-robin CPU ports in RUN.
    always_comb begin
        ibus_gnt_s    = 1'b0;
        dbus_gnt_s    = 1'b0;
        rr_d          = rr_q;
        bus.ram_adr   = {ADDR_W{1'b0}};
        bus.ram_wren  = 4'b0000;
        bus.ram_di    = 32'h0000_0000;
        if (bus.dbg_mem_op) begin
            bus.ram_adr  = bus.dbg_adr[ADDR_W+1:2];
            bus.ram_wren = bus.dbg_wren;
            bus.ram_di   = bus.dbg_do;
        end else if (state_q == ST_RUN) begin
            ibus_gnt_s = bus.ibus_cmd_valid && (!bus.dbus_cmd_valid || rr_q);
            dbus_gnt_s = bus.dbus_cmd_valid && !ibus_gnt_s;
            if (dbus_gnt_s) begin
                bus.ram_adr  = bus.dbus_adr[ADDR_W+1:2];
                bus.ram_wren = bus.dbus_wr ? bus.dbus_mask : 4'b0000;
                bus.ram_di   = bus.dbus_wdata;
                rr_d         = 1'b1;
            end else if (ibus_gnt_s) begin
                bus.ram_adr  = bus.ibus_adr[ADDR_W+1:2];
                rr_d         = 1'b0;
            end else begin
                rr_d         = rr_q;
            end
        end else begin
            rr_d = rr_q;
        end
    end

    // Response and debug-capture bookkeeping; read data arrives one cycle after the address.
    always_comb begin
        ibus_rsp_valid_d = ibus_gnt_s;
        dbus_rsp_valid_d = dbus_gnt_s && !bus.dbus_wr;
        dbg_rd_d         = bus.dbg_mem_op && (bus.dbg_wren == 4'b0000);
        dbg_di_d         = dbg_rd_q ? bus.ram_do : dbg_di_q;
        cpu_n_reset_d    = (state_d == ST_RUN);
    end

    // State, counter, arbitration pointer and response flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q          <= ST_RST;
            cnt_q            <= HOLD_INIT;
            rr_q             <= 1'b1;
            cpu_n_reset_q    <= 1'b0;
            ibus_rsp_valid_q <= 1'b0;
            dbus_rsp_valid_q <= 1'b0;
            dbg_rd_q         <= 1'b0;
            dbg_di_q         <= 32'h0000_0000;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            rr_q             <= rr_d;
            cpu_n_reset_q    <= cpu_n_reset_d;
            ibus_rsp_valid_q <= ibus_rsp_valid_d;
            dbus_rsp_valid_q <= dbus_rsp_valid_d;
            dbg_rd_q         <= dbg_rd_d;
            dbg_di_q         <= dbg_di_d;
        end
    end

    assign bus.ibus_cmd_ready = ibus_gnt_s;
    assign bus.dbus_cmd_ready = dbus_gnt_s;
    assign bus.ibus_rsp_valid = ibus_rsp_valid_q;
    assign bus.dbus_rsp_valid = dbus_rsp_valid_q;
    assign bus.ibus_rsp_data  = bus.ram_do;
    assign bus.dbus_rsp_data  = bus.ram_do;
    // Debug read data is visible in the cycle after the read and then held.
    assign bus.dbg_di         = dbg_rd_q ? bus.ram_do : dbg_di_q;
    assign cpu_n_reset        = cpu_n_reset_q;

endmodule

// File: tb/tb_cvex_mem_arbiter.sv
// Scoreboard bench for cvex_mem_arbiter: stimulus pushes expected CPU read
// responses (data and arrival cycle); a monitor pops them when rsp_valid rises.
module tb_cvex_mem_arbiter;

    logic clk = 1'b0;
    logic n_reset;
    logic cpu_n_reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t iq[$];
    exp_t dq[$];

    logic [31:0] mem [0:16383];

    always #5 clk = ~clk;

    cvex_mem_arbiter_if #(.ADDR_W(14)) bus ();

    cvex_mem_arbiter #(.ADDR_W(14), .RST_HOLD(4)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .bus         (bus.slave),
        .cpu_n_reset (cpu_n_reset)
    );

    // RAM model: byte-write, synchronous read
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (bus.ram_wren[b]) mem[bus.ram_adr][b*8 +: 8] <= bus.ram_di[b*8 +: 8];
        bus.ram_do <= mem[bus.ram_adr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // monitor: compare responses against the scoreboard queues
    always @(negedge clk) begin
        if (bus.ibus_rsp_valid) begin
            if (iq.size() == 0) chk("ibus_unexpected_rsp", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = iq.pop_front();
                chk("ibus_rsp_data", bus.ibus_rsp_data, e.data);
                chk("ibus_rsp_cycle", cyc, e.cyc);
            end
        end else if (iq.size() > 0 && iq[0].cyc <= cyc) begin
            chk("ibus_rsp_missing", 32'd0, 32'd1);
            void'(iq.pop_front());
        end
        if (bus.dbus_rsp_valid) begin
            if (dq.size() == 0) chk("dbus_unexpected_rsp", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = dq.pop_front();
                chk("dbus_rsp_data", bus.dbus_rsp_data, e.data);
                chk("dbus_rsp_cycle", cyc, e.cyc);
            end
        end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
            chk("dbus_rsp_missing", 32'd0, 32'd1);
            void'(dq.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_i(logic [31:0] d);
        exp_t e;
        e.data = d;
        e.cyc  = cyc + 1;
        iq.push_back(e);
    endtask

    task automatic push_d(logic [31:0] d);
        exp_t e;
        e.data = d;
        e.cyc  = cyc + 1;
        dq.push_back(e);
    endtask

    initial begin
        #20000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        n_reset            = 1'b0;
        bus.dbg_mem_op     = 1'b0;
        bus.dbg_wren       = 4'h0;
        bus.dbg_adr        = 32'h0;
        bus.dbg_do         = 32'h0;
        bus.ibus_cmd_valid = 1'b0;
        bus.ibus_adr       = 32'h0;
        bus.dbus_cmd_valid = 1'b0;
        bus.dbus_wr        = 1'b0;
        bus.dbus_mask      = 4'h0;
        bus.dbus_adr       = 32'h0;
        bus.dbus_wdata     = 32'h0;

        // reset values
        step(); step();
        @(negedge clk);
        chk("rst_cpu_n_reset", cpu_n_reset, 32'd0);
        chk("rst_ibus_rsp_valid", bus.ibus_rsp_valid, 32'd0);
        chk("rst_dbus_rsp_valid", bus.dbus_rsp_valid, 32'd0);
        chk("rst_dbg_di", bus.dbg_di, 32'h0);
        chk("rst_ram_wren", bus.ram_wren, 32'h0);
        step();

        // release: cpu_n_reset rises 5 cycles after n_reset, readies stay 0
        n_reset = 1'b1;
        bus.ibus_cmd_valid = 1'b1;
        bus.dbus_cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_cpu_n_reset", cpu_n_reset, 32'd0);
            chk("hold_ibus_ready", bus.ibus_cmd_ready, 32'd0);
            chk("hold_dbus_ready", bus.dbus_cmd_ready, 32'd0);
            step();
        end
        bus.ibus_cmd_valid = 1'b0;
        bus.dbus_cmd_valid = 1'b0;
        @(negedge clk);
        chk("release_cpu_n_reset", cpu_n_reset, 32'd1);
        step();

        // debug load: two writes, one read back, fetch held pending
        bus.ibus_cmd_valid = 1'b1;
        bus.ibus_adr       = 32'h0002_0000;
        bus.dbg_mem_op     = 1'b1;
        bus.dbg_wren       = 4'hF;
        bus.dbg_adr        = 32'h0002_0000;
        bus.dbg_do         = 32'h0001_0137;
        @(negedge clk);
        chk("dbg_ibus_ready", bus.ibus_cmd_ready, 32'd0);
        step();
        bus.dbg_adr = 32'h0002_0004;
        bus.dbg_do  = 32'hFF01_0113;
        @(negedge clk);
        chk("dbg_cpu_n_reset", cpu_n_reset, 32'd0);
        chk("dbg_ibus_ready", bus.ibus_cmd_ready, 32'd0);
        step();
        bus.dbg_wren = 4'h0;
        @(negedge clk);
        chk("dbg_cpu_n_reset", cpu_n_reset, 32'd0);
        step();
        bus.dbg_mem_op = 1'b0;
        @(negedge clk);
        chk("dbg_read_data", bus.dbg_di, 32'hFF01_0113);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("post_dbg_cpu_n_reset", cpu_n_reset, 32'd0);
            chk("post_dbg_ibus_ready", bus.ibus_cmd_ready, 32'd0);
            step();
        end
        @(negedge clk);
        chk("post_dbg_release", cpu_n_reset, 32'd1);
        chk("first_fetch_ready", bus.ibus_cmd_ready, 32'd1);
        push_i(32'h0001_0137);
        step();
        bus.ibus_cmd_valid = 1'b0;

        // byte-masked write then read
        bus.dbus_cmd_valid = 1'b1;
        bus.dbus_wr        = 1'b1;
        bus.dbus_mask      = 4'hF;
        bus.dbus_adr       = 32'h0000_FFFC;
        bus.dbus_wdata     = 32'h0002_0088;
        @(negedge clk);
        chk("wr_full_ready", bus.dbus_cmd_ready, 32'd1);
        chk("wr_full_wren", bus.ram_wren, 32'hF);
        step();
        bus.dbus_mask  = 4'h2;
        bus.dbus_wdata = 32'h0000_AA00;
        @(negedge clk);
        chk("wr_mask_wren", bus.ram_wren, 32'h2);
        step();
        bus.dbus_wr = 1'b0;
        @(negedge clk);
        chk("rd_ready", bus.dbus_cmd_ready, 32'd1);
        chk("rd_wren", bus.ram_wren, 32'h0);
        push_d(32'h0002_AA88);
        step();

        // round-robin: both valid for 4 cycles, pointer at dbus
        bus.ibus_cmd_valid = 1'b1;
        bus.ibus_adr       = 32'h0002_0004;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                chk("rr_ibus_ready", bus.ibus_cmd_ready, 32'd1);
                chk("rr_dbus_ready", bus.dbus_cmd_ready, 32'd0);
                push_i(32'hFF01_0113);
            end else begin
                chk("rr_ibus_ready", bus.ibus_cmd_ready, 32'd0);
                chk("rr_dbus_ready", bus.dbus_cmd_ready, 32'd1);
                push_d(32'h0002_AA88);
            end
            step();
        end
        bus.ibus_cmd_valid = 1'b0;

        // debug preemption right after a dbus read
        bus.dbus_adr = 32'h0002_0000;
        @(negedge clk);
        chk("pre_dbus_ready", bus.dbus_cmd_ready, 32'd1);
        push_d(32'h0001_0137);
        step();
        bus.dbus_cmd_valid = 1'b0;
        bus.ibus_cmd_valid = 1'b1;
        bus.ibus_adr       = 32'h0002_0000;
        bus.dbg_mem_op     = 1'b1;
        bus.dbg_wren       = 4'h0;
        bus.dbg_adr        = 32'h0000_FFFC;
        @(negedge clk);
        chk("preempt_ibus_ready", bus.ibus_cmd_ready, 32'd0);
        step();
        // address wrap: 0x10000 aliases word 0
        bus.dbg_wren = 4'hF;
        bus.dbg_adr  = 32'h0001_0000;
        bus.dbg_do   = 32'h1234_5678;
        @(negedge clk);
        chk("preempt_ibus_ready", bus.ibus_cmd_ready, 32'd0);
        chk("preempt_cpu_n_reset", cpu_n_reset, 32'd0);
        chk("preempt_dbg_di", bus.dbg_di, 32'h0002_AA88);
        step();
        bus.dbg_wren = 4'h0;
        bus.dbg_adr  = 32'h0000_0000;
        @(negedge clk);
        chk("dbg_di_hold", bus.dbg_di, 32'h0002_AA88);
        step();
        bus.dbg_mem_op     = 1'b0;
        bus.ibus_cmd_valid = 1'b0;
        @(negedge clk);
        chk("wrap_dbg_di", bus.dbg_di, 32'h1234_5678);
        t = 0;
        while (cpu_n_reset !== 1'b1 && t < 20) begin
            step();
            @(negedge clk);
            t++;
        end
        chk("wrap_release", cpu_n_reset, 32'd1);
        chk("wrap_release_latency", t, 32'd5);
        chk("dbg_di_held", bus.dbg_di, 32'h1234_5678);
        step();
        bus.dbus_cmd_valid = 1'b1;
        bus.dbus_wr        = 1'b0;
        bus.dbus_adr       = 32'h0004_0000;
        @(negedge clk);
        chk("wrap_rd_ready", bus.dbus_cmd_ready, 32'd1);
        push_d(32'h1234_5678);
        step();

        // reset coinciding with an accepted read drops its response
        bus.dbus_adr = 32'h0000_FFFC;
        n_reset      = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", bus.dbus_cmd_ready, 32'd1);
        step();
        bus.dbus_cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_rsp_valid", bus.dbus_rsp_valid, 32'd0);
        chk("rst_mid_cpu_n_reset", cpu_n_reset, 32'd0);
        step();
        n_reset = 1'b1;
        step(); step();

        chk("scoreboard_drained", iq.size() + dq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
